// File: rtl/target_bbox_pkg.sv
// -----------------------------------------------------------------------------
// target_bbox_pkg
// Shared definitions for the frame bounding-box extractor:
//   - state_e     : two-state frame control (IDLE = not armed, ACCUM = armed)
//   - MIN_RESET   : value loaded into running min registers (all ones)
//   - MAX_RESET   : value loaded into running max registers (all zeros)
//   - RUN_W       : width of the optional horizontal run counter
// Coordinate constants are sized to COORD_W_MAX bits and sliced by users,
// so any coordinate width up to COORD_W_MAX is supported.
// -----------------------------------------------------------------------------
package target_bbox_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    localparam int unsigned COORD_W_MAX = 16;

    localparam logic [COORD_W_MAX-1:0] MIN_RESET = '1;
    localparam logic [COORD_W_MAX-1:0] MAX_RESET = '0;

    localparam int unsigned RUN_W = 4;

endpackage : target_bbox_pkg

// File: rtl/target_bbox_pix_coord_cnt.sv
// -----------------------------------------------------------------------------
// pix_coord_cnt
// Saturating pixel coordinate tracker for one video frame.
//   clk, rst_n  : pixel clock, asynchronous active-low reset
//   vs_rise_i   : frame start strobe, returns both counters to 0
//   de_i        : pixel valid
//   de_fall_i   : end-of-line strobe (de was high last cycle, low now)
//   x_o, y_o    : coordinate of the pixel presented in the current de cycle
// x is 0 during the first de cycle of a line and advances after each de cycle,
// so x_o always names the pixel being presented. y advances once per line.
// Both counters stick at H_ACT-1 / V_ACT-1 instead of wrapping.
// -----------------------------------------------------------------------------
module pix_coord_cnt #(
    parameter int unsigned H_ACT = 1280,
    parameter int unsigned V_ACT = 720,
    parameter int unsigned XW    = 11,
    parameter int unsigned YW    = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vs_rise_i,
    input  logic          de_i,
    input  logic          de_fall_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o
);

    localparam logic [XW-1:0] X_LAST = XW'(H_ACT - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACT - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        x_d = x_q;
        y_d = y_q;
        if (vs_rise_i) begin
            x_d = '0;
            y_d = '0;
        end else if (de_fall_i) begin
            x_d = '0;
            if (y_q != Y_LAST) begin
                y_d = y_q + 1'b1;
            end
        end else if (de_i) begin
            if (x_q != X_LAST) begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;

endmodule : pix_coord_cnt

// File: rtl/target_bbox.sv
// -----------------------------------------------------------------------------
// target_bbox
// Frame-level bounding-box extractor for a binarized (1-bit) video stream.
// Tracks pixel coordinates, accumulates min/max column and row of white
// pixels plus the white-pixel count, and publishes a latched result with a
// one-cycle strobe on the cycle that first samples post_vsync low.
//
// Ports:
//   clk, rst_n        : pixel clock, asynchronous active-low reset
//   post_vsync        : frame valid (high for the whole active frame)
//   post_href         : line valid (not used by this block)
//   post_de           : pixel valid
//   monoc             : 1 = white pixel, sampled only while post_de = 1
//   bbox_valid        : one-cycle strobe, result registers were updated
//   bbox_found        : last frame held at least one counted pixel
//   x_min, x_max      : column bounds of the last frame
//   y_min, y_max      : row bounds of the last frame
//   pix_cnt           : counted white pixels of the last frame (saturating)
//
// Build option:
//   BBOX_NOISE_FILTER_EN : when defined, a white pixel is counted only as part
//   of a horizontal run of at least MIN_RUN consecutive white de pixels.
// -----------------------------------------------------------------------------
module target_bbox
    import target_bbox_pkg::*;
#(
    parameter int unsigned H_ACT   = 1280,
    parameter int unsigned V_ACT   = 720,
    parameter int unsigned XW      = 11,
    parameter int unsigned YW      = 10,
    parameter int unsigned CW      = 21,
    parameter int unsigned MIN_RUN = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          post_vsync,
    input  logic          post_href,
    input  logic          post_de,
    input  logic          monoc,
    output logic          bbox_valid,
    output logic          bbox_found,
    output logic [XW-1:0] x_min,
    output logic [XW-1:0] x_max,
    output logic [YW-1:0] y_min,
    output logic [YW-1:0] y_max,
    output logic [CW-1:0] pix_cnt
);

    // Largest per-pixel count increment is MIN_RUN (the filter credits a
    // whole run at once), so the increment is sized to hold it.
    localparam int unsigned ADD_W = $clog2(MIN_RUN + 1);

    localparam logic [XW-1:0] X_MIN_RST = MIN_RESET[XW-1:0];
    localparam logic [XW-1:0] X_MAX_RST = MAX_RESET[XW-1:0];
    localparam logic [YW-1:0] Y_MIN_RST = MIN_RESET[YW-1:0];
    localparam logic [YW-1:0] Y_MAX_RST = MAX_RESET[YW-1:0];

    logic unused_href;
    assign unused_href = post_href;

    // ---------------------------------------------------------------- edges
    logic vsync_q, de_q;
    logic vs_rise, vs_fall, de_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Reset to 1 so releasing reset in the middle of a frame is not
            // mistaken for a frame start; the next genuine rise re-arms.
            vsync_q <= 1'b1;
            de_q    <= 1'b0;
        end else begin
            vsync_q <= post_vsync;
            de_q    <= post_de;
        end
    end

    assign vs_rise = post_vsync & ~vsync_q;
    assign vs_fall = ~post_vsync & vsync_q;
    assign de_fall = ~post_de & de_q;

    // ---------------------------------------------------------- coordinates
    logic [XW-1:0] x_cur;
    logic [YW-1:0] y_cur;

    pix_coord_cnt #(
        .H_ACT (H_ACT),
        .V_ACT (V_ACT),
        .XW    (XW),
        .YW    (YW)
    ) u_coord (
        .clk       (clk),
        .rst_n     (rst_n),
        .vs_rise_i (vs_rise),
        .de_i      (post_de),
        .de_fall_i (de_fall),
        .x_o       (x_cur),
        .y_o       (y_cur)
    );

    // ------------------------------------------------------- frame control
    state_e state_q, state_d;
    logic   armed;
    logic   publish;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A rise while already in ACCUM stays in ACCUM; the accumulator logic
    // below clears on every rise, so a glitch simply restarts the frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (vs_rise) state_d = ACCUM;
            ACCUM:   if (vs_fall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        armed   = (state_q == ACCUM);
        publish = armed & vs_fall;
    end

    // ------------------------------------------------------ pixel qualifier
    logic             take;
    logic [XW-1:0]    lo_x;
    logic [ADD_W-1:0] add;

`ifdef BBOX_NOISE_FILTER_EN
    logic [RUN_W-1:0] run_q, run_d;
    logic             run_first, run_more;

    always_comb begin
        run_d = run_q;
        if (vs_rise || !post_de || !monoc) begin
            run_d = '0;
        end else if (run_q != RUN_W'(MIN_RUN)) begin
            run_d = run_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end

    // run_q counts the white pixels before this one in the current run, so
    // the MIN_RUN-th pixel credits the whole run back to its start column.
    assign run_first = post_de & monoc & (run_q == RUN_W'(MIN_RUN - 1));
    assign run_more  = post_de & monoc & (run_q == RUN_W'(MIN_RUN));
    assign take      = run_first | run_more;
    assign lo_x      = run_first ? (x_cur - XW'(MIN_RUN - 1)) : x_cur;
    assign add       = run_first ? ADD_W'(MIN_RUN) : ADD_W'(1);
`else
    assign take = post_de & monoc;
    assign lo_x = x_cur;
    assign add  = ADD_W'(1);
`endif

    // ---------------------------------------------------------- accumulators
    logic [XW-1:0] acc_xmin_q, acc_xmin_d, acc_xmax_q, acc_xmax_d;
    logic [YW-1:0] acc_ymin_q, acc_ymin_d, acc_ymax_q, acc_ymax_d;
    logic [CW-1:0] acc_cnt_q, acc_cnt_d;
    logic [CW:0]   cnt_sum;

    assign cnt_sum = {1'b0, acc_cnt_q} + (CW + 1)'(add);

    always_comb begin
        acc_xmin_d = acc_xmin_q;
        acc_xmax_d = acc_xmax_q;
        acc_ymin_d = acc_ymin_q;
        acc_ymax_d = acc_ymax_q;
        acc_cnt_d  = acc_cnt_q;
        if (vs_rise) begin
            acc_xmin_d = X_MIN_RST;
            acc_xmax_d = X_MAX_RST;
            acc_ymin_d = Y_MIN_RST;
            acc_ymax_d = Y_MAX_RST;
            acc_cnt_d  = '0;
        end else if (armed && post_vsync && take) begin
            if (lo_x < acc_xmin_q)  acc_xmin_d = lo_x;
            if (x_cur > acc_xmax_q) acc_xmax_d = x_cur;
            if (y_cur < acc_ymin_q) acc_ymin_d = y_cur;
            if (y_cur > acc_ymax_q) acc_ymax_d = y_cur;
            acc_cnt_d = cnt_sum[CW] ? '1 : cnt_sum[CW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_xmin_q <= X_MIN_RST;
            acc_xmax_q <= X_MAX_RST;
            acc_ymin_q <= Y_MIN_RST;
            acc_ymax_q <= Y_MAX_RST;
            acc_cnt_q  <= '0;
        end else begin
            acc_xmin_q <= acc_xmin_d;
            acc_xmax_q <= acc_xmax_d;
            acc_ymin_q <= acc_ymin_d;
            acc_ymax_q <= acc_ymax_d;
            acc_cnt_q  <= acc_cnt_d;
        end
    end

    // ------------------------------------------------------ published result
    logic          valid_q, valid_d, found_q, found_d;
    logic [XW-1:0] out_xmin_q, out_xmin_d, out_xmax_q, out_xmax_d;
    logic [YW-1:0] out_ymin_q, out_ymin_d, out_ymax_q, out_ymax_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;

    always_comb begin
        valid_d    = publish;
        found_d    = found_q;
        out_xmin_d = out_xmin_q;
        out_xmax_d = out_xmax_q;
        out_ymin_d = out_ymin_q;
        out_ymax_d = out_ymax_q;
        out_cnt_d  = out_cnt_q;
        if (publish) begin
            found_d = (acc_cnt_q != '0);
            // An empty frame still holds the min-reset pattern, so the
            // bounds are forced to 0 rather than copied.
            if (acc_cnt_q != '0) begin
                out_xmin_d = acc_xmin_q;
                out_xmax_d = acc_xmax_q;
                out_ymin_d = acc_ymin_q;
                out_ymax_d = acc_ymax_q;
                out_cnt_d  = acc_cnt_q;
            end else begin
                out_xmin_d = '0;
                out_xmax_d = '0;
                out_ymin_d = '0;
                out_ymax_d = '0;
                out_cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            found_q    <= 1'b0;
            out_xmin_q <= '0;
            out_xmax_q <= '0;
            out_ymin_q <= '0;
            out_ymax_q <= '0;
            out_cnt_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            found_q    <= found_d;
            out_xmin_q <= out_xmin_d;
            out_xmax_q <= out_xmax_d;
            out_ymin_q <= out_ymin_d;
            out_ymax_q <= out_ymax_d;
            out_cnt_q  <= out_cnt_d;
        end
    end

    assign bbox_valid = valid_q;
    assign bbox_found = found_q;
    assign x_min      = out_xmin_q;
    assign x_max      = out_xmax_q;
    assign y_min      = out_ymin_q;
    assign y_max      = out_ymax_q;
    assign pix_cnt    = out_cnt_q;

endmodule : target_bbox

// File: tb/tb_target_bbox.sv
// -----------------------------------------------------------------------------
// tb_target_bbox
// Self-checking bench for target_bbox with a 16x8 active area. Two instances
// share the stimulus: u_dut (CW = 21) and u_sat (CW = 6, saturating count).
// Frames are described by up to two white rectangles per record; expected
// results are hand-computed, with the noise-filter build using its own column.
// -----------------------------------------------------------------------------
module tb_target_bbox;

`ifdef BBOX_NOISE_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic        clk, rst_n;
    logic        vsync, href, de, monoc;

    logic        valid, found;
    logic [10:0] xmin, xmax;
    logic [9:0]  ymin, ymax;
    logic [20:0] cnt;

    logic        s_valid, s_found;
    logic [10:0] s_xmin, s_xmax;
    logic [9:0]  s_ymin, s_ymax;
    logic [5:0]  s_cnt;

    target_bbox #(.H_ACT(16), .V_ACT(8), .XW(11), .YW(10), .CW(21), .MIN_RUN(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .post_vsync(vsync), .post_href(href), .post_de(de),
        .monoc(monoc), .bbox_valid(valid), .bbox_found(found), .x_min(xmin),
        .x_max(xmax), .y_min(ymin), .y_max(ymax), .pix_cnt(cnt)
    );

    target_bbox #(.H_ACT(16), .V_ACT(8), .XW(11), .YW(10), .CW(6), .MIN_RUN(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .post_vsync(vsync), .post_href(href), .post_de(de),
        .monoc(monoc), .bbox_valid(s_valid), .bbox_found(s_found), .x_min(s_xmin),
        .x_max(s_xmax), .y_min(s_ymin), .y_max(s_ymax), .pix_cnt(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign href = de;

    typedef struct {
        string name;
        int    ax0, ax1, ay0, ay1;
        int    bx0, bx1, by0, by1;
        int    line_len;
        int    found, xmin, xmax, ymin, ymax, cnt, cnt_sat;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_white(input vec_t v, input int x, input int y);
        return (x >= v.ax0 && x <= v.ax1 && y >= v.ay0 && y <= v.ay1) ||
               (x >= v.bx0 && x <= v.bx1 && y >= v.by0 && y <= v.by1);
    endfunction

    function automatic vec_t mk(input string name, input int ax0, ax1, ay0, ay1,
                                input int bx0, bx1, by0, by1, input int line_len,
                                input int f, x0, x1, y0, y1, c, cs);
        vec_t v;
        v.name = name;
        v.ax0 = ax0; v.ax1 = ax1; v.ay0 = ay0; v.ay1 = ay1;
        v.bx0 = bx0; v.bx1 = bx1; v.by0 = by0; v.by1 = by1;
        v.line_len = line_len;
        v.found = f; v.xmin = x0; v.xmax = x1; v.ymin = y0; v.ymax = y1;
        v.cnt = c; v.cnt_sat = cs;
        return v;
    endfunction

    // One line of pixels for row y followed by blanking (except after row 7,
    // where de and vsync drop together).
    task automatic drive_line(input vec_t v, input int y);
        for (int x = 0; x < v.line_len; x++) begin
            de    = 1'b1;
            monoc = is_white(v, x, y);
            cycle();
        end
        de    = 1'b0;
        monoc = 1'b0;
        if (y < 7) repeat (3) cycle();
    endtask

    task automatic run_frame(input vec_t v);
        int n;
        vsync = 1'b1;
        repeat (3) cycle();
        for (int y = 0; y < 8; y++) drive_line(v, y);
        vsync = 1'b0;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!valid && n < 8);
        check({v.name, ".latency"}, n, 1);
        check({v.name, ".sat_valid"}, int'(s_valid), 1);
        check({v.name, ".found"}, int'(found), v.found);
        check({v.name, ".x_min"}, int'(xmin), v.xmin);
        check({v.name, ".x_max"}, int'(xmax), v.xmax);
        check({v.name, ".y_min"}, int'(ymin), v.ymin);
        check({v.name, ".y_max"}, int'(ymax), v.ymax);
        check({v.name, ".pix_cnt"}, int'(cnt), v.cnt);
        check({v.name, ".sat_cnt"}, int'(s_cnt), v.cnt_sat);
        cycle();
        check({v.name, ".strobe_width"}, int'(valid), 0);
        repeat (3) cycle();
    endtask

    vec_t vecs[7];

    initial begin
        int pulses;
        // Rectangles with x0 > x1 are empty.
        vecs[0] = mk("single_5_3", 5, 5, 3, 3, 1, 0, 0, 0, 16,
                     FILT ? 0 : 1, FILT ? 0 : 5, FILT ? 0 : 5, FILT ? 0 : 3, FILT ? 0 : 3,
                     FILT ? 0 : 1, FILT ? 0 : 1);
        vecs[1] = mk("all_black", 1, 0, 0, 0, 1, 0, 0, 0, 16, 0, 0, 0, 0, 0, 0, 0);
        vecs[2] = mk("rect", 2, 9, 1, 4, 1, 0, 0, 0, 16, 1, 2, 9, 1, 4, 32, 32);
        vecs[3] = mk("single_0_7", 0, 0, 7, 7, 1, 0, 0, 0, 16,
                     FILT ? 0 : 1, 0, 0, FILT ? 0 : 7, FILT ? 0 : 7,
                     FILT ? 0 : 1, FILT ? 0 : 1);
        vecs[4] = mk("two_runs", 0, 2, 2, 2, 6, 11, 2, 2, 16,
                     1, FILT ? 6 : 0, 11, 2, 2, FILT ? 6 : 9, FILT ? 6 : 9);
        vecs[5] = mk("all_white", 0, 15, 0, 7, 1, 0, 0, 0, 16, 1, 0, 15, 0, 7, 128, 63);
        vecs[6] = mk("long_line", 0, 17, 0, 0, 1, 0, 0, 0, 18, 1, 0, 15, 0, 0, 18, 18);

        rst_n = 1'b0;
        vsync = 1'b0;
        de    = 1'b0;
        monoc = 1'b0;
        repeat (3) cycle();
        check("reset.valid", int'(valid), 0);
        check("reset.found", int'(found), 0);
        check("reset.x_min", int'(xmin), 0);
        check("reset.x_max", int'(xmax), 0);
        check("reset.y_min", int'(ymin), 0);
        check("reset.y_max", int'(ymax), 0);
        check("reset.pix_cnt", int'(cnt), 0);
        rst_n = 1'b1;
        repeat (2) cycle();

        // Reset pulsed in the middle of a frame: that frame's fall must not
        // strobe and outputs stay at their reset values.
        vsync = 1'b1;
        repeat (3) cycle();
        for (int y = 0; y < 4; y++) drive_line(vecs[2], y);
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        cycle();
        for (int y = 4; y < 8; y++) drive_line(vecs[2], y);
        vsync  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (valid || s_valid) pulses++;
        end
        check("midreset.strobes", pulses, 0);
        check("midreset.found", int'(found), 0);
        check("midreset.pix_cnt", int'(cnt), 0);
        check("midreset.x_max", int'(xmax), 0);
        check("midreset.y_max", int'(ymax), 0);

        // The full frames that follow must report normally; rect then
        // single_0_7 checks that a new frame replaces the old result.
        run_frame(vecs[2]);
        run_frame(vecs[3]);
        for (int i = 0; i < 7; i++) run_frame(vecs[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_target_bbox
